// File: rtl/ifetch_pkg.sv
// Shared fetch-path constants and the queue entry record.
package ifetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; pointers carry one extra wrap bit.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = wptr - rptr;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clock) begin
    if (do_push && !flush && !reset) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: single-outstanding ROM fetch feeding a prefetch queue.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        IMEM_AW  = 14,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                        clock,
  input  logic                        reset,
  output logic                        imem_en,
  output logic [IMEM_AW-1:0]          imem_addr,
  input  logic [31:0]                 imem_rdata,
  input  logic                        redirect,
  input  logic [ADDR_W-1:0]           redirect_pc,
  output logic                        inst_valid,
  input  logic                        inst_ready,
  output logic [31:0]                 instruction,
  output logic [ADDR_W-1:0]           inst_pc,
  output logic [ADDR_W-1:0]           branch_base_addr,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  inflight_pc;
  logic               inflight;
  logic               issue;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  // Reserve a slot for the outstanding fetch so its data always has room.
  assign issue     = !reset && !redirect && ((32'(occupancy) + 32'(inflight)) < DEPTH);
  assign imem_en   = issue;
  assign imem_addr = fetch_pc[IMEM_AW+1:2];

  assign push       = inflight && !redirect;
  assign inst_valid = (occupancy != '0) && !redirect;
  assign pop        = inst_valid && inst_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~ADDR_W'(3);
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) fetch_pc <= fetch_pc + ADDR_W'(4);
    end
  end

  always_ff @(posedge clock) begin
    if (issue) inflight_pc <= fetch_pc;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .wdata ({inflight_pc, imem_rdata}),
    .pop   (pop),
    .rdata (head),
    .count (occupancy)
  );

  assign inst_pc          = head[ENTRY_W-1:INSTR_W];
  assign instruction      = head[INSTR_W-1:0];
  assign branch_base_addr = inst_pc + ADDR_W'(4);

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: queue-level reference model plus directed literal checks.
module tb_ifetch_queue;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, redirect, inst_ready;
  logic [31:0] redirect_pc;
  logic        imem_en, inst_valid;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata, instruction, inst_pc, branch_base_addr;
  logic [2:0]  occupancy;

  logic        w_reset, w_redirect, w_ready;
  logic [31:0] w_redirect_pc;
  logic        w_en, w_valid;
  logic [13:0] w_addr;
  logic [31:0] w_rdata, w_instr, w_pc, w_bba;
  logic [2:0]  w_occ;

  ifetch_queue u_dut (
    .clock(clock), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction),
    .inst_pc(inst_pc), .branch_base_addr(branch_base_addr), .occupancy(occupancy)
  );

  ifetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clock(clock), .reset(w_reset), .imem_en(w_en), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .inst_valid(w_valid), .inst_ready(w_ready), .instruction(w_instr),
    .inst_pc(w_pc), .branch_base_addr(w_bba), .occupancy(w_occ)
  );

  // ROM: word n holds n; unrequested cycles return a poison pattern.
  always @(posedge clock) begin
    imem_rdata <= imem_en ? 32'(imem_addr) : 32'hDEAD_BEEF;
    w_rdata    <= w_en ? 32'(w_addr) : 32'hDEAD_BEEF;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return (pc >> 2) & 32'h0000_3FFF;
  endfunction

  // Reference model: list of queued PCs, one pending fetch, next fetch PC.
  logic [31:0] mq[$];
  bit          pend = 1'b0;
  bit          live = 1'b0;
  logic [31:0] pend_pc, m_pc;

  always @(negedge clock) begin
    bit          exp_en;
    bit          exp_v;
    logic [31:0] hp;
    exp_en = !reset && !redirect && ((mq.size() + int'(pend)) < 4);
    exp_v  = (mq.size() > 0) && !redirect;
    if (live) begin
      chk("m_imem_en", 32'(imem_en), 32'(exp_en));
      if (exp_en) chk("m_imem_addr", 32'(imem_addr), rom_word(m_pc));
      chk("m_occupancy", 32'(occupancy), 32'(mq.size()));
      chk("m_inst_valid", 32'(inst_valid), 32'(exp_v));
      if (exp_v) begin
        hp = mq[0];
        chk("m_inst_pc", inst_pc, hp);
        chk("m_instruction", instruction, rom_word(hp));
        chk("m_branch_base", branch_base_addr, hp + 32'd4);
      end
    end
    if (reset) begin
      mq.delete();
      pend = 1'b0;
      m_pc = 32'h0;
      live = 1'b1;
    end else if (live) begin
      if (redirect) begin
        mq.delete();
        pend = 1'b0;
        m_pc = redirect_pc & ~32'd3;
      end else begin
        if (exp_v && inst_ready) void'(mq.pop_front());
        if (pend) mq.push_back(pend_pc);
        pend = exp_en;
        if (exp_en) begin
          pend_pc = m_pc;
          m_pc    = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    w_reset = 1'b1; w_redirect = 1'b0; w_redirect_pc = '0; w_ready = 1'b1;
    tick(); tick();
    reset = 1'b0; w_reset = 1'b0;

    // First cycle out of reset issues RESET_PC.
    at_neg();
    chk("c0_en", 32'(imem_en), 32'd1);
    chk("c0_addr", 32'(imem_addr), 32'd0);
    chk("c0_valid", 32'(inst_valid), 32'd0);
    chk("c0_occ", 32'(occupancy), 32'd0);
    tick(); at_neg();
    chk("c1_valid", 32'(inst_valid), 32'd0);
    tick(); at_neg();
    chk("c2_valid", 32'(inst_valid), 32'd1);
    chk("c2_pc", inst_pc, 32'h0);
    chk("c2_instr", instruction, 32'h0);
    chk("w2_pc", w_pc, 32'hFFFF_FFF8);
    chk("w2_instr", w_instr, 32'h0000_3FFE);
    tick(); at_neg();
    chk("c3_pc", inst_pc, 32'h4);
    chk("c3_instr", instruction, 32'h1);
    chk("w3_pc", w_pc, 32'hFFFF_FFFC);
    chk("w3_instr", w_instr, 32'h0000_3FFF);

    // Redirect with 0x8 at the head.
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0103;
    at_neg();
    chk("r_head_pc", inst_pc, 32'h8);
    chk("r_valid", 32'(inst_valid), 32'd0);
    chk("r_en", 32'(imem_en), 32'd0);
    chk("w4_pc", w_pc, 32'h0);
    chk("w4_instr", w_instr, 32'h0);
    tick(); redirect = 1'b0;
    at_neg();
    chk("r1_en", 32'(imem_en), 32'd1);
    chk("r1_addr", 32'(imem_addr), 32'h40);
    chk("r1_valid", 32'(inst_valid), 32'd0);
    tick(); at_neg();
    chk("r2_valid", 32'(inst_valid), 32'd0);
    tick(); at_neg();
    chk("r3_valid", 32'(inst_valid), 32'd1);
    chk("r3_pc", inst_pc, 32'h100);
    chk("r3_instr", instruction, 32'h40);
    chk("r3_bba", branch_base_addr, 32'h104);

    // Back-to-back redirects: last one wins.
    tick(); redirect = 1'b1; redirect_pc = 32'h40;
    tick(); redirect_pc = 32'h80;
    at_neg();
    chk("bb_valid", 32'(inst_valid), 32'd0);
    tick(); redirect = 1'b0;
    at_neg();
    chk("bb_addr", 32'(imem_addr), 32'h20);
    tick(); tick(); at_neg();
    chk("bb_valid2", 32'(inst_valid), 32'd1);
    chk("bb_pc", inst_pc, 32'h80);

    // Fill to 3 entries with a fetch in flight, then pulse reset.
    tick(); inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    tick(); redirect = 1'b0;
    tick(); tick(); tick();
    tick(); reset = 1'b1;
    at_neg();
    chk("pre_rst_occ", 32'(occupancy), 32'd3);
    tick(); reset = 1'b0;
    at_neg();
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_en", 32'(imem_en), 32'd1);
    chk("rst_addr", 32'(imem_addr), 32'd0);

    // Stall for 10 cycles: queue saturates, fetch stops.
    repeat (9) tick();
    at_neg();
    chk("st_occ", 32'(occupancy), 32'd4);
    chk("st_en", 32'(imem_en), 32'd0);
    chk("st_pc", inst_pc, 32'h0);
    tick(); inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("drain_valid", 32'(inst_valid), 32'd1);
      chk("drain_pc", inst_pc, 32'(4 * k));
      chk("drain_instr", instruction, 32'(k));
      tick();
    end
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
